seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-controller bus: digit load/control inputs and the multiplexed segment/anode outputs.
interface seg_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] digits;
    logic                  load;
    logic                  blank_lz;
    logic [BRIGHT_W-1:0]   brightness;
    logic                  blink_en;
    logic [N_DIGITS-1:0]   blink_mask;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output digits, load, blank_lz, brightness, blink_en, blink_mask,
        input  seg, an, frame_done
    );

    modport slave (
        input  digits, load, blank_lz, brightness, blink_en, blink_mask,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: frame-aligned digit update, hex decode,
// leading-zero blanking, PWM brightness on the anodes and per-digit blinking.
module seg_scan_driver #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BRIGHT_W     = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DIG_W = 4 * N_DIGITS;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [CNT_W-1:0]    presc_q;
    logic [IDX_W-1:0]    index_q;
    logic [BRIGHT_W-1:0] pwm_q;
    logic [BF_W-1:0]     blink_cnt_q;
    logic                blink_hide_q;
    logic [DIG_W-1:0]    pending_q;
    logic                pending_valid_q;
    logic [DIG_W-1:0]    shadow_q;
    logic                shadow_valid_q;
    logic [6:0]          seg_q;
    logic [N_DIGITS-1:0] an_q;
    logic                frame_done_q;

    logic                tick_c;
    logic                boundary_c;
    logic [3:0]          cur_digit_c;
    logic                lz_sel_c;
    logic                mask_sel_c;
    logic                run_zero_c;
    logic [6:0]          seg_d;
    logic [N_DIGITS-1:0] an_d;

    // Active-low hex decode, {g,f,e,d,c,b,a}; A..F are display glyphs, not hex letters.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_OFF;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h7F;
            4'hB: s = 7'h3F;
            4'hC: s = 7'h40;
            4'hD: s = 7'h41;
            4'hE: s = 7'h06;
            4'hF: s = 7'h77;
        endcase
        return s;
    endfunction

    assign tick_c     = (presc_q == CNT_W'(TICK_DIV - 1));
    assign boundary_c = tick_c && (index_q == IDX_W'(N_DIGITS - 1));

    // Select the scanned digit and its blanking attributes; zero-run is scanned from the top digit down.
    always_comb begin
        cur_digit_c = '0;
        lz_sel_c    = 1'b0;
        mask_sel_c  = 1'b0;
        run_zero_c  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero_c = run_zero_c & (shadow_q[4*i +: 4] == 4'd0);
            if (index_q == IDX_W'(i)) begin
                cur_digit_c = shadow_q[4*i +: 4];
                lz_sel_c    = run_zero_c && (i != 0);
                mask_sel_c  = bus.blink_mask[i];
            end
        end
    end

    // Next segment/anode values; blanking touches seg only, PWM touches an only.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if (shadow_valid_q) begin
            seg_d = decode(cur_digit_c);
            if (bus.blank_lz && lz_sel_c) begin
                seg_d = SEG_OFF;
            end
            if (bus.blink_en && blink_hide_q && mask_sel_c) begin
                seg_d = SEG_OFF;
            end
            if (pwm_q <= bus.brightness) begin
                an_d = ~(N_DIGITS'(1) << index_q);
            end
        end
    end

    // Slot timing: prescaler, scan index, free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            index_q <= '0;
            pwm_q   <= '0;
        end else begin
            pwm_q   <= pwm_q + BRIGHT_W'(1);
            presc_q <= tick_c ? '0 : presc_q + CNT_W'(1);
            if (tick_c) begin
                index_q <= (index_q == IDX_W'(N_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
            end
        end
    end

    // Blink phase toggles every BLINK_FRAMES frame boundaries, starting visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q  <= '0;
            blink_hide_q <= 1'b0;
        end else if (boundary_c) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_q  <= '0;
                blink_hide_q <= ~blink_hide_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BF_W'(1);
            end
        end
    end

    // Pending/shadow double buffer; a load on the boundary cycle goes straight to the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shadow_q        <= '0;
            shadow_valid_q  <= 1'b0;
        end else if (boundary_c) begin
            if (bus.load) begin
                shadow_q       <= bus.digits;
                shadow_valid_q <= 1'b1;
            end else if (pending_valid_q) begin
                shadow_q       <= pending_q;
                shadow_valid_q <= 1'b1;
            end
            pending_valid_q <= 1'b0;
        end else if (bus.load) begin
            pending_q       <= bus.digits;
            pending_valid_q <= 1'b1;
        end
    end

    // Output registers, one clock behind index/shadow/controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= boundary_c;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule
